spi_periph: RTL and testbench

SPI peripheral (target-side) front end that sits directly upstream of the register controller. It converts the external 4-wire SPI pins into the controller's byte-wide MMIO handshake. Each received byte goes to the controller's `din`, qualified by `dvalid`. The controller's `dout` byte is serialised back on `miso` during the next byte slot. All SPI pins are oversampled in the `clk` domain; there is no second clock.

---
 rtl/spi_periph_if.sv | 16 +
 rtl/spi_periph.sv | 170 +++++++++++++++++
 tb/tb_spi_periph.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_periph_if.sv
// spi_periph_if: byte-wide handshake between the SPI peripheral front end and
// the register controller.
//   tx_data  : byte the controller wants shifted out on miso (controller dout)
//   rx_data  : last complete byte received from the SPI master (controller din)
//   rx_valid : rx_data is stable and no byte is in progress (controller dvalid)
// Modports:
//   master : controller side (drives tx_data, observes rx_data/rx_valid)
//   slave  : peripheral side (observes tx_data, drives rx_data/rx_valid)
interface spi_periph_if;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (output tx_data, input rx_data, input rx_valid);
    modport slave  (input tx_data, output rx_data, output rx_valid);
endinterface

// File: rtl/spi_periph.sv
// spi_periph: SPI mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit target front end.
// All SPI pins are oversampled in the clk domain; sclk must run at no more
// than clk/8.
// Ports:
//   clk       : system clock, all state on the rising edge
//   rst       : asynchronous active-low reset
//   sclk      : SPI clock pin (asynchronous)
//   cs_n      : SPI chip select pin, active-low (asynchronous)
//   mosi      : SPI data in pin (asynchronous)
//   miso      : SPI data out pin
//   frame_err : one-cycle pulse when a frame ends on a partial byte
//               (only present when SPI_PERIPH_FRAME_ERR_EN is defined)
//   bus       : controller handshake (tx_data in, rx_data/rx_valid out)
// Optional feature macro: SPI_PERIPH_FRAME_ERR_EN
module spi_periph (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
`ifdef SPI_PERIPH_FRAME_ERR_EN
    output logic       frame_err,
`endif
    spi_periph_if.slave bus
);

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t state, state_nxt;

    logic sclk_p0, sclk_p1, sclk_p2;
    logic cs_p0, cs_p1, cs_p2;
    logic mosi_p0, mosi_p1, mosi_p2;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-1:0] rx_shift;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic [2:0]        bit_cnt;
    logic              byte_done;

    // Synchronizer (_p0, _p1), edge register (_p2) and registered strobes.
    // mosi is delayed alongside sclk so the sample lines up with sclk_rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_p0   <= 1'b0;
            sclk_p1   <= 1'b0;
            sclk_p2   <= 1'b0;
            cs_p0     <= 1'b1;
            cs_p1     <= 1'b1;
            cs_p2     <= 1'b1;
            mosi_p0   <= 1'b0;
            mosi_p1   <= 1'b0;
            mosi_p2   <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            sclk_p0   <= sclk;
            sclk_p1   <= sclk_p0;
            sclk_p2   <= sclk_p1;
            cs_p0     <= cs_n;
            cs_p1     <= cs_p0;
            cs_p2     <= cs_p1;
            mosi_p0   <= mosi;
            mosi_p1   <= mosi_p0;
            mosi_p2   <= mosi_p1;
            sclk_rise <= sclk_p1 & ~sclk_p2;
            sclk_fall <= ~sclk_p1 & sclk_p2;
            cs_fall   <= ~cs_p1 & cs_p2;
            cs_rise   <= cs_p1 & ~cs_p2;
        end
    end

    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    // Frame state machine; chip-select strobes take priority over sclk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall)   state_nxt = SHIFT;
                SHIFT:   if (byte_done) state_nxt = HOLD;
                HOLD:    if (sclk_fall) state_nxt = SHIFT;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Shift datapath and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_shift   <= '0;
            rx_shift   <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b1;
            bit_cnt    <= 3'd0;
            miso       <= 1'b0;
`ifdef SPI_PERIPH_FRAME_ERR_EN
            frame_err  <= 1'b0;
`endif
        end else begin
`ifdef SPI_PERIPH_FRAME_ERR_EN
            frame_err  <= 1'b0;
`endif
            if (cs_rise) begin
                // A partial byte is simply dropped: rx_data keeps the last
                // complete byte and becomes valid again.
                miso       <= 1'b0;
                rx_valid_q <= 1'b1;
                bit_cnt    <= 3'd0;
`ifdef SPI_PERIPH_FRAME_ERR_EN
                frame_err  <= (state == SHIFT) && (bit_cnt != 3'd0);
`endif
            end else begin
                case (state)
                    IDLE: begin
                        miso       <= 1'b0;
                        rx_valid_q <= 1'b1;
                        if (cs_fall) begin
                            tx_shift   <= bus.tx_data;
                            miso       <= bus.tx_data[7];
                            bit_cnt    <= 3'd0;
                            rx_valid_q <= 1'b0;
                        end
                    end
                    SHIFT: begin
                        if (sclk_rise) begin
                            rx_shift   <= {rx_shift[6:0], mosi_p2};
                            bit_cnt    <= bit_cnt + 3'd1;
                            rx_valid_q <= 1'b0;
                            if (byte_done) rx_data_q <= {rx_shift[6:0], mosi_p2};
                        end else if (sclk_fall) begin
                            tx_shift <= {tx_shift[6:0], 1'b0};
                            miso     <= tx_shift[6];
                        end
                    end
                    HOLD: begin
                        // Valid rises the cycle after rx_data is written.
                        rx_valid_q <= 1'b1;
                        if (sclk_fall) begin
                            tx_shift <= bus.tx_data;
                            miso     <= bus.tx_data[7];
                        end
                    end
                    default: begin
                        miso       <= 1'b0;
                        rx_valid_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_periph.sv
// tb_spi_periph: self-checking bench for spi_periph. An SPI master is modelled
// with directed byte transfers; a frame-level model tracks what rx_data,
// rx_valid, miso (and frame_err) must be, and the DUT is compared against that
// model, delayed by the fixed pin-to-output latency, on every clock cycle.
module tb_spi_periph;

    logic clk;
    logic rst;
    logic sclk;
    logic cs_n;
    logic mosi;
    logic miso;
    logic frame_err;

    spi_periph_if bus ();

    spi_periph dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
`ifdef SPI_PERIPH_FRAME_ERR_EN
        .frame_err (frame_err),
`endif
        .bus       (bus.slave)
    );

`ifndef SPI_PERIPH_FRAME_ERR_EN
    assign frame_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    int fe_pulses = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Frame-level model. It reacts to pin edges as seen at each rising clk
    // edge; the DUT reacts 3 clk later (2 sync flops + edge register).
    // hist[0] is the model's current output, hist[3] the DUT's expected one.
    // Packing: {rx_data[7:0], rx_valid, miso, frame_err}.
    // ------------------------------------------------------------------
    logic [10:0] hist [4];
    logic        m_cs_prev, m_sclk_prev, m_active, m_rxv, m_rxv_pend, m_miso, m_fe;
    logic [7:0]  m_rxd, m_acc, m_tx;
    int          m_nbits;

    always @(posedge clk) begin
        if (!rst) begin
            m_cs_prev = 1'b1; m_sclk_prev = 1'b0; m_active = 1'b0;
            m_rxv = 1'b1; m_rxv_pend = 1'b0; m_miso = 1'b0; m_fe = 1'b0;
            m_rxd = 8'h00; m_acc = 8'h00; m_tx = 8'h00; m_nbits = 0;
            for (int i = 0; i < 4; i++) hist[i] = {8'h00, 1'b1, 1'b0, 1'b0};
        end else begin
            for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
            m_fe = 1'b0;
            if (m_rxv_pend) begin
                m_rxv = 1'b1;
                m_rxv_pend = 1'b0;
            end
            if (m_cs_prev && !cs_n) begin
                m_active = 1'b1; m_nbits = 0;
                m_tx = bus.tx_data; m_miso = m_tx[7]; m_rxv = 1'b0;
            end else if (!m_cs_prev && cs_n) begin
                if (m_active && (m_nbits % 8) != 0) m_fe = 1'b1;
                m_active = 1'b0; m_miso = 1'b0; m_rxv = 1'b1; m_rxv_pend = 1'b0;
            end else if (m_active) begin
                if (!m_sclk_prev && sclk) begin
                    m_acc = {m_acc[6:0], mosi};
                    m_nbits++;
                    m_rxv = 1'b0;
                    if ((m_nbits % 8) == 0) begin
                        m_rxd = m_acc;
                        m_rxv_pend = 1'b1;
                    end
                end else if (m_sclk_prev && !sclk) begin
                    if ((m_nbits % 8) == 0) m_tx = bus.tx_data;
                    else                    m_tx = m_tx << 1;
                    m_miso = m_tx[7];
                end
            end
`ifndef SPI_PERIPH_FRAME_ERR_EN
            m_fe = 1'b0;
`endif
            hist[0] = {m_rxd, m_rxv, m_miso, m_fe};
            m_cs_prev = cs_n;
            m_sclk_prev = sclk;
        end
    end

    // Per-cycle compare of DUT outputs against the delayed model.
    logic [10:0] exp_v;
    always @(posedge clk) begin
        #1;
        exp_v = hist[3];
        check("cyc_rx_data",  bus.rx_data,         exp_v[10:3]);
        check("cyc_rx_valid", {7'd0, bus.rx_valid}, {7'd0, exp_v[2]});
        check("cyc_miso",     {7'd0, miso},         {7'd0, exp_v[1]});
        check("cyc_frame_err",{7'd0, frame_err},    {7'd0, exp_v[0]});
        if (frame_err === 1'b1) fe_pulses++;
    end

    // ------------------------------------------------------------------
    // SPI master. Pins change on the falling clk edge, far from the DUT's
    // sampling edge. h is the sclk half period in clk cycles.
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] mo, input int h, input logic [7:0] next_tx,
                        input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int k = 0; k < nbits; k++) begin
            mosi = mo[7-k];
            tick(h);
            mi[7-k] = miso;
            sclk = 1'b1;
            if (k == 7) begin
                tick(h - 2);
                bus.tx_data = next_tx;
                tick(2);
            end else begin
                tick(h);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic frame1(input logic [7:0] tx, input logic [7:0] mo, input int h,
                          output logic [7:0] mi);
        bus.tx_data = tx;
        tick(2);
        cs_n = 1'b0;
        tick(6);
        xfer(mo, h, tx, 8, mi);
        tick(h);
        cs_n = 1'b1;
        tick(8);
    endtask

    logic [7:0] mi1, mi2;

    initial begin
        rst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        bus.tx_data = 8'h00;

        // Reset and idle behaviour.
        tick(10);
        check("rst_rx_valid", {7'd0, bus.rx_valid}, 8'h01);
        check("rst_rx_data",  bus.rx_data, 8'h00);
        check("rst_miso",     {7'd0, miso}, 8'h00);
        rst = 1'b1;
        tick(4);
        mosi = 1'b1;
        bus.tx_data = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            sclk = ~sclk;
            tick(4);
        end
        sclk = 1'b0; mosi = 1'b0;
        tick(8);
        check("idle_rx_data",  bus.rx_data, 8'h00);
        check("idle_rx_valid", {7'd0, bus.rx_valid}, 8'h01);
        check("idle_miso",     {7'd0, miso}, 8'h00);

        // Single byte: tx 3C, mosi A5.
        bus.tx_data = 8'h3C;
        tick(2);
        cs_n = 1'b0;
        tick(6);
        check("sb_rx_valid_low", {7'd0, bus.rx_valid}, 8'h00);
        xfer(8'hA5, 4, 8'h3C, 8, mi1);
        tick(6);
        check("sb_rx_data",  bus.rx_data, 8'hA5);
        check("sb_rx_valid", {7'd0, bus.rx_valid}, 8'h01);
        check("sb_miso_byte", mi1, 8'h3C);
        cs_n = 1'b1;
        tick(8);

        // Two bytes in one frame: mosi 80 then 00, tx 3C then 07.
        bus.tx_data = 8'h3C;
        tick(2);
        cs_n = 1'b0;
        tick(6);
        xfer(8'h80, 8, 8'h07, 8, mi1);
        tick(2);
        check("tb_rx_data1",  bus.rx_data, 8'h80);
        check("tb_rx_valid1", {7'd0, bus.rx_valid}, 8'h01);
        xfer(8'h00, 8, 8'h07, 8, mi2);
        tick(4);
        check("tb_rx_data2",  bus.rx_data, 8'h00);
        check("tb_miso_byte1", mi1, 8'h3C);
        check("tb_miso_byte2", mi2, 8'h07);
        cs_n = 1'b1;
        tick(8);

        // Abort after 5 bits of FF, previous byte A5.
        frame1(8'h11, 8'hA5, 4, mi1);
        check("ab_prev_rx_data", bus.rx_data, 8'hA5);
        bus.tx_data = 8'h22;
        tick(2);
        cs_n = 1'b0;
        tick(6);
        xfer(8'hFF, 4, 8'h22, 5, mi1);
        tick(4);
        cs_n = 1'b1;
        tick(8);
        check("ab_rx_data",  bus.rx_data, 8'hA5);
        check("ab_rx_valid", {7'd0, bus.rx_valid}, 8'h01);
`ifdef SPI_PERIPH_FRAME_ERR_EN
        check("ab_frame_err_pulses", fe_pulses[7:0], 8'h01);
`else
        check("ab_frame_err_pulses", fe_pulses[7:0], 8'h00);
`endif

        // Reset after 3 bits, then a full 5A frame.
        bus.tx_data = 8'hFF;
        tick(2);
        cs_n = 1'b0;
        tick(6);
        xfer(8'hFF, 4, 8'hFF, 3, mi1);
        rst = 1'b0; cs_n = 1'b1; sclk = 1'b0;
        tick(1);
        check("mr_rx_data",  bus.rx_data, 8'h00);
        check("mr_rx_valid", {7'd0, bus.rx_valid}, 8'h01);
        check("mr_miso",     {7'd0, miso}, 8'h00);
        tick(5);
        rst = 1'b1;
        tick(4);
        frame1(8'h00, 8'h5A, 4, mi1);
        check("mr_after_rx_data", bus.rx_data, 8'h5A);

        // Loopback at fastest and slowest sclk.
        frame1(8'h55, 8'hAA, 4, mi1);
        check("fast_rx_data", bus.rx_data, 8'hAA);
        check("fast_miso",    mi1, 8'h55);
        frame1(8'hAA, 8'h55, 32, mi2);
        check("slow_rx_data", bus.rx_data, 8'h55);
        check("slow_miso",    mi2, 8'hAA);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
